// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard receiver: filtered clock, frame FSM, F0/E0 prefix handling.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat of the held key.
module ps2_teclado_rx #(
    parameter int FILTRO  = 8,
    parameter int TIMEOUT = 50000,
    parameter int TW      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] Cambio,
    output logic       got_data,
    output logic [7:0] estado,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} st_t;

    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    st_t              st_q, st_d;
    logic [1:0]       ck_s_q, dt_s_q;
    logic [FILTRO-1:0] flt_q, flt_d;
    logic             fclk_q, fclk_d, fclk_p_q;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             par_q, par_d;
    logic [TW-1:0]    to_q, to_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             brk_q, brk_d, ext_q, ext_d;
    logic [7:0]       cambio_q, cambio_d, estado_q, estado_d;
    logic             got_q, got_d;
    logic             fall, dat, tmo, rep;

    assign fall = fclk_p_q & ~fclk_q;
    assign dat  = dt_s_q[1];
    assign tmo  = (st_q != IDLE) && !fall && (to_q == TO_MAX);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign rep = (estado_q != 8'h00) && (sh_q == estado_q);
`else
    assign rep = 1'b0;
`endif

    assign flt_d = {flt_q[FILTRO-2:0], ck_s_q[1]};

    always_comb begin
        fclk_d = fclk_q;
        if (&flt_q) fclk_d = 1'b1;
        else if (~|flt_q) fclk_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck_s_q   <= 2'b11;
            dt_s_q   <= 2'b11;
            flt_q    <= '1;
            fclk_q   <= 1'b1;
            fclk_p_q <= 1'b1;
        end else begin
            ck_s_q   <= {ck_s_q[0], ps2_clk};
            dt_s_q   <= {dt_s_q[0], ps2_data};
            flt_q    <= flt_d;
            fclk_q   <= fclk_d;
            fclk_p_q <= fclk_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st_q <= IDLE;
        else      st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (tmo) begin
            st_d = IDLE;
        end else if (fall) begin
            unique case (st_q)
                IDLE:    if (!dat) st_d = DATA;
                DATA:    if (cnt_q == 3'd7) st_d = PARITY;
                PARITY:  st_d = STOP;
                STOP:    st_d = IDLE;
                default: st_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        par_d = par_q;
        vld_d = 1'b0;
        err_d = tmo;
        if (fall) begin
            unique case (st_q)
                IDLE: begin
                    cnt_d = 3'd0;
                    err_d = dat;
                end
                DATA: begin
                    sh_d  = {dat, sh_q[7:1]};
                    cnt_d = cnt_q + 3'd1;
                end
                PARITY: par_d = dat;
                STOP: begin
                    if (dat && ^{sh_q, par_q}) vld_d = 1'b1;
                    else                       err_d = 1'b1;
                end
                default: ;
            endcase
        end
        to_d = (st_q == IDLE || fall || tmo) ? '0 : to_q + TW'(1);
    end

    // Byte handling runs one cycle after the frame completes.
    always_comb begin
        got_d    = 1'b0;
        cambio_d = cambio_q;
        estado_d = estado_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        if (vld_q) begin
            if (sh_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (sh_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                if (sh_q == estado_q) estado_d = 8'h00;
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (!rep) begin
                cambio_d = sh_q;
                estado_d = sh_q;
                got_d    = 1'b1;
                ext_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q     <= 8'h00;
            cnt_q    <= 3'd0;
            par_q    <= 1'b0;
            to_q     <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            cambio_q <= 8'h00;
            estado_q <= 8'h00;
            got_q    <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            to_q     <= to_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            cambio_q <= cambio_d;
            estado_q <= estado_d;
            got_q    <= got_d;
        end
    end

    assign Cambio    = cambio_q;
    assign estado    = estado_q;
    assign got_data  = got_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// Testbench for ps2_teclado_rx: directed and random PS/2 frames
// against a byte-level keyboard model.
module tb_ps2_teclado_rx;

    localparam int FILTRO  = 8;
    localparam int TIMEOUT = 1000;
    localparam int TW      = 10;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit TYPF = 1'b1;
`else
    localparam bit TYPF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] Cambio, estado;
    logic       got_data, frame_err;

    ps2_teclado_rx #(
        .FILTRO (FILTRO),
        .TIMEOUT(TIMEOUT),
        .TW     (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .Cambio   (Cambio),
        .got_data (got_data),
        .estado   (estado),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   got_n = 0;
    int   err_n = 0;
    logic got_p = 1'b0;
    logic err_p = 1'b0;
    logic both_seen = 1'b0;
    logic long_seen = 1'b0;

    always @(negedge clk) begin
        if (got_data) got_n <= got_n + 1;
        if (frame_err) err_n <= err_n + 1;
        if (got_data && frame_err) both_seen <= 1'b1;
        if ((got_data && got_p) || (frame_err && err_p)) long_seen <= 1'b1;
        got_p <= got_data;
        err_p <= frame_err;
    end

    int         hp = 25;
    logic [7:0] m_cambio = 8'h00;
    logic [7:0] m_estado = 8'h00;
    bit         m_brk = 1'b0;
    int         exp_got = 0;
    int         exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_bit(input logic b);
        ps2_data = b;
        repeat (hp) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (hp) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip,
                              input int nbits);
        logic [10:0] fr;
        fr = {1'b1, ~^b ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) clk_bit(fr[i]);
        ps2_data = 1'b1;
        repeat (hp + 20) @(posedge clk);
    endtask

    // Keyboard semantics: F0 arms a release, E0 is ignored, others are makes.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
        end else if (m_brk) begin
            if (b == m_estado) m_estado = 8'h00;
            m_brk = 1'b0;
        end else if (!(TYPF && m_estado != 8'h00 && b == m_estado)) begin
            m_cambio = b;
            m_estado = b;
            exp_got++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        send_frame(b, 1'b0, 11);
        model_byte(b);
        chk({tag, ":Cambio"}, 32'(Cambio), 32'(m_cambio));
        chk({tag, ":estado"}, 32'(estado), 32'(m_estado));
        chk({tag, ":got_cnt"}, 32'(got_n), 32'(exp_got));
        chk({tag, ":err_cnt"}, 32'(err_n), 32'(exp_err));
    endtask

    initial begin
        int g0;
        int n;
        repeat (5) @(posedge clk);
        #1;
        chk("rst:Cambio", 32'(Cambio), 32'h0);
        chk("rst:estado", 32'(estado), 32'h0);
        chk("rst:got", 32'(got_data), 32'h0);
        chk("rst:err", 32'(frame_err), 32'h0);
        @(negedge clk) rst = 1'b1;
        repeat (20) @(posedge clk);

        send_byte(8'h75, "make75");
        send_byte(8'hF0, "brk75");
        send_byte(8'h75, "rel75");

        send_byte(8'hE0, "e0a");
        send_byte(8'h72, "make72");
        send_byte(8'hE0, "e0b");
        send_byte(8'hF0, "brk72");
        send_byte(8'h72, "rel72");

        send_frame(8'h73, 1'b1, 11);
        exp_err++;
        chk("par:err_cnt", 32'(err_n), 32'(exp_err));
        chk("par:got_cnt", 32'(got_n), 32'(exp_got));
        chk("par:Cambio", 32'(Cambio), 32'(m_cambio));

        send_frame(8'h5A, 1'b0, 5);
        chk("to:early", 32'(err_n), 32'(exp_err));
        repeat (TIMEOUT + 10) @(posedge clk);
        exp_err++;
        chk("to:err_cnt", 32'(err_n), 32'(exp_err));
        chk("to:got_cnt", 32'(got_n), 32'(exp_got));
        send_byte(8'h6C, "after_to");

        g0 = got_n;
        send_byte(8'h73, "rep1");
        send_byte(8'h73, "rep2");
        send_byte(8'h73, "rep3");
        chk("rep:pulses", 32'(got_n - g0), TYPF ? 32'd1 : 32'd3);
        send_byte(8'hF0, "repbrk");
        send_byte(8'h73, "reprel");

        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(posedge clk);
        chk("glitch:err", 32'(err_n), 32'(exp_err));
        chk("glitch:got", 32'(got_n), 32'(exp_got));

        send_frame(8'h1C, 1'b0, 10);
        ps2_data = 1'b1;
        repeat (hp) @(posedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (!got_data && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lat:seen", 32'(got_data), 32'h1);
        chk("lat:window", 32'(n >= FILTRO + 4 && n <= FILTRO + 8), 32'h1);
        repeat (hp) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (hp + 20) @(posedge clk);
        model_byte(8'h1C);
        chk("lat:Cambio", 32'(Cambio), 32'(m_cambio));
        chk("lat:got_cnt", 32'(got_n), 32'(exp_got));

        for (int k = 0; k < 8; k++) begin
            logic [7:0] c;
            bit ex, rel;
            int reps;
            hp   = int'($urandom_range(20, 32));
            c    = 8'($urandom_range(1, 8'hDF));
            ex   = 1'($urandom_range(0, 1));
            rel  = 1'($urandom_range(0, 1));
            reps = int'($urandom_range(1, 2));
            for (int r = 0; r < reps; r++) begin
                if (ex) send_byte(8'hE0, "rnd_e0");
                send_byte(c, "rnd_make");
            end
            if (rel) begin
                if (ex) send_byte(8'hE0, "rnd_e0r");
                send_byte(8'hF0, "rnd_brk");
                send_byte(c, "rnd_rel");
            end
        end
        hp = 25;

        send_byte(8'h29, "pre_rst");
        send_frame(8'h55, 1'b0, 5);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst:Cambio", 32'(Cambio), 32'h0);
        chk("arst:estado", 32'(estado), 32'h0);
        chk("arst:got", 32'(got_data), 32'h0);
        chk("arst:err", 32'(frame_err), 32'h0);
        m_cambio = 8'h00;
        m_estado = 8'h00;
        m_brk    = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (200) @(posedge clk);
        chk("arst:got_cnt", 32'(got_n), 32'(exp_got));
        chk("arst:err_cnt", 32'(err_n), 32'(exp_err));
        send_byte(8'h5A, "post_rst");

        chk("both_high", 32'(both_seen), 32'h0);
        chk("long_pulse", 32'(long_seen), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
